// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: requester id type, reset value of the last-granted id, default burst cap.
package mem_arb_pkg;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

  // Requester 1 is recorded as last granted out of reset so the first tie goes to requester 0.
  localparam req_id_t LAST_RST = 1'b1;

  // Default cap on consecutive lock-held grants to one requester.
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/arb_rr2_pick.sv
// Two-way round-robin winner selection with a lock-hold override.
// Latency: purely combinational.
// Backpressure: none; a losing requester simply sees no grant bit this cycle.
// Ports: req_i  - request vector {req1, req0}
//        last_i - id of the requester granted most recently
//        hold_i - lock is active and still within its burst cap (implies req_i[last_i])
//        gnt_o  - one-hot grant, all zero when nobody requests
module arb_rr2_pick
  import mem_arb_pkg::*;
(
  input  logic    [1:0] req_i,
  input  req_id_t       last_i,
  input  logic          hold_i,
  output logic    [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (hold_i) begin
      gnt_o[last_i] = 1'b1;
    end else if (&req_i) begin
      // Tie without a valid lock: whoever was not served last wins.
      gnt_o[~last_i] = 1'b1;
    end else begin
      // Zero or one requester: pass it straight through.
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/mem_arb2.sv
// Shares one single-port synchronous memory between two requesters, round-robin with a capped lock.
// Latency: grant is same-cycle; read data and rvldN arrive one cycle after the grant.
// Backpressure: a requester holds reqN and its qualifiers until gntN; a loser waits, nothing is dropped.
// Ports: clk, rstb         - clock and asynchronous active-low reset
//        reqN/weN/lockN    - request, write select, keep-ownership request (N = 0, 1)
//        addN/datwN        - address and write data of requester N
//        gntN              - combinational accept; rvldN - registered read-data valid
//        rdat              - read data, qualified by rvld0/rvld1
//        mem_*             - memory port (enable, write enable, address, write data, read data)
module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter int ADD_WIDTH = 8,
  parameter int DAT_WIDTH = 8,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 req0,
  input  logic                 we0,
  input  logic                 lock0,
  input  logic [ADD_WIDTH-1:0] add0,
  input  logic [DAT_WIDTH-1:0] datw0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic                 lock1,
  input  logic [ADD_WIDTH-1:0] add1,
  input  logic [DAT_WIDTH-1:0] datw1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvld0,
  output logic                 rvld1,
  output logic [DAT_WIDTH-1:0] rdat,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADD_WIDTH-1:0] mem_add,
  output logic [DAT_WIDTH-1:0] mem_datw,
  input  logic [DAT_WIDTH-1:0] mem_datr
);

  localparam int             CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  req_id_t       last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_vld_q, lock_vld_d;
  logic [1:0]    rvld_q, rvld_d;

  logic [1:0]    req;
  logic          hold;
  logic [1:0]    pick_gnt;
  logic [1:0]    gnt;
  logic          any_gnt;
  req_id_t       win_id;
  logic          win_lock;

  assign req  = {req1, req0};
  assign hold = lock_vld_q & req[last_q] & (cnt_q < CNT_MAX);

  arb_rr2_pick u_pick (
    .req_i  (req),
    .last_i (last_q),
    .hold_i (hold),
    .gnt_o  (pick_gnt)
  );

  // Nothing may reach the memory while reset is asserted.
  assign gnt     = pick_gnt & {2{rstb}};
  assign any_gnt = |gnt;
  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];

  // With no grant the mux rests on requester 0.
  assign win_id   = gnt[1];
  assign win_lock = win_id ? lock1 : lock0;

  assign mem_en   = any_gnt;
  assign mem_we   = any_gnt & (win_id ? we1 : we0);
  assign mem_add  = win_id ? add1 : add0;
  assign mem_datw = win_id ? datw1 : datw0;

  // Memory read data is registered in the macro, so it lines up with rvld_q.
  assign rdat  = mem_datr;
  assign rvld0 = rvld_q[0];
  assign rvld1 = rvld_q[1];

  always_comb begin
    last_d     = last_q;
    cnt_d      = '0;
    lock_vld_d = 1'b0;
    if (any_gnt) begin
      last_d     = win_id;
      lock_vld_d = win_lock;
      // A streak continues only across consecutive grant cycles to the same id;
      // an idle cycle zeroes cnt, so the next grant restarts at 1.
      if ((win_id == last_q) && (cnt_q != '0)) begin
        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
      end else begin
        cnt_d = CNT_ONE;
      end
    end
  end

  // Writes return write-through data from the memory, which nobody wants.
  assign rvld_d = {gnt[1] & ~we1, gnt[0] & ~we0};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q     <= LAST_RST;
      cnt_q      <= '0;
      lock_vld_q <= 1'b0;
      rvld_q     <= 2'b00;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      lock_vld_q <= lock_vld_d;
      rvld_q     <= rvld_d;
    end
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2 with a behavioural single-port memory (1-cycle registered read, write-through).
// Inputs change 1ns after each rising edge; outputs are sampled 2ns after the edge.
module tb_mem_arb2;

  logic       clk = 1'b0;
  logic       rstb;
  logic       req0, we0, lock0, req1, we1, lock1;
  logic [7:0] add0, datw0, add1, datw1;
  logic       gnt0, gnt1, rvld0, rvld1;
  logic [7:0] rdat;
  logic       mem_en, mem_we;
  logic [7:0] mem_add, mem_datw, mem_datr;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  mem_arb2 #(.ADD_WIDTH(8), .DAT_WIDTH(8), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .req0     (req0),
    .we0      (we0),
    .lock0    (lock0),
    .add0     (add0),
    .datw0    (datw0),
    .req1     (req1),
    .we1      (we1),
    .lock1    (lock1),
    .add1     (add1),
    .datw1    (datw1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvld0    (rvld0),
    .rvld1    (rvld1),
    .rdat     (rdat),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_add  (mem_add),
    .mem_datw (mem_datw),
    .mem_datr (mem_datr)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_add] <= mem_datw;
        mem_datr     <= mem_datw;
      end else begin
        mem_datr <= mem[mem_add];
      end
    end
  end

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; lock0 = 0; add0 = 8'h00; datw0 = 8'h00;
    req1 = 0; we1 = 0; lock1 = 0; add1 = 8'h00; datw1 = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    req0 = 1; req1 = 1;
    rstb = 0;
    #2;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: gnt1gnt0=%b%b required 00", gnt1, gnt0); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en: en=%b we=%b required 0 0", mem_en, mem_we); end
    step();
    checks++; if (rvld0 !== 1'b0 || rvld1 !== 1'b0) begin errors++; $display("FAIL reset_rvld: rvld1rvld0=%b%b required 00", rvld1, rvld0); end
    checks++; if (dut.cnt_q !== 3'd0 || dut.lock_vld_q !== 1'b0 || dut.last_q !== 1'b1) begin
      errors++; $display("FAIL reset_state: cnt=%0d lock_vld=%b last=%b required 0 0 1", dut.cnt_q, dut.lock_vld_q, dut.last_q);
    end
    idle_inputs();
    rstb = 1;
    step();
  endtask

  // Both read without lock: grants alternate starting with requester 0.
  task automatic test_alternate();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    req0 = 1; add0 = 8'h10; req1 = 1; add1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({gnt1, gnt0} !== exp_g[i]) begin errors++; $display("FAIL alt_gnt[%0d]: gnt=%b required %b", i, {gnt1, gnt0}, exp_g[i]); end
      checks++; if (mem_add !== (exp_g[i][1] ? 8'h20 : 8'h10) || mem_en !== 1'b1 || mem_we !== 1'b0) begin
        errors++; $display("FAIL alt_mem[%0d]: add=%h en=%b we=%b", i, mem_add, mem_en, mem_we);
      end
      @(posedge clk); #1;
      checks++; if ({rvld1, rvld0} !== exp_g[i]) begin errors++; $display("FAIL alt_rvld[%0d]: rvld=%b required %b", i, {rvld1, rvld0}, exp_g[i]); end
      checks++; if (rdat !== (exp_g[i][1] ? 8'h3C : 8'hC3)) begin errors++; $display("FAIL alt_rdat[%0d]: rdat=%h required %h", i, rdat, exp_g[i][1] ? 8'h3C : 8'hC3); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write_read();
    req1 = 1; we1 = 1; add1 = 8'h33; datw1 = 8'hA5;
    #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b1 || mem_datw !== 8'hA5 || mem_add !== 8'h33) begin
      errors++; $display("FAIL wr_issue: gnt=%b%b we=%b datw=%h add=%h required 10 1 a5 33", gnt1, gnt0, mem_we, mem_datw, mem_add);
    end
    @(posedge clk); #1;
    checks++; if (rvld1 !== 1'b0 || rvld0 !== 1'b0) begin errors++; $display("FAIL wr_no_rvld: rvld=%b%b required 00", rvld1, rvld0); end
    we1 = 0;
    #1;
    checks++; if (gnt1 !== 1'b1 || mem_we !== 1'b0 || mem_add !== 8'h33) begin errors++; $display("FAIL rd_issue: gnt1=%b we=%b add=%h required 1 0 33", gnt1, mem_we, mem_add); end
    @(posedge clk); #1;
    checks++; if (rvld1 !== 1'b1 || rvld0 !== 1'b0 || rdat !== 8'hA5) begin
      errors++; $display("FAIL raw_data: rvld=%b%b rdat=%h required 10 a5", rvld1, rvld0, rdat);
    end
    idle_inputs();
    step();
  endtask

  // Lock burst capped at 4, then requester 1, then requester 0 again.
  task automatic test_lock_burst();
    logic [1:0] exp_g [6];
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
    exp_g[3] = 2'b01; exp_g[4] = 2'b10; exp_g[5] = 2'b01;
    req0 = 1; lock0 = 1; add0 = 8'h10; req1 = 1; add1 = 8'h20;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if ({gnt1, gnt0} !== exp_g[i]) begin errors++; $display("FAIL burst_gnt[%0d]: gnt=%b required %b", i, {gnt1, gnt0}, exp_g[i]); end
      @(posedge clk); #1;
    end
    idle_inputs();
    step();
  endtask

  // Lone lock holder keeps the port past the cap; req1 wins once the cap is hit.
  task automatic test_lone_saturate();
    logic [1:0] exp_g;
    req0 = 1; lock0 = 1; add0 = 8'h10;
    for (int c = 1; c <= 10; c++) begin
      req1 = (c == 6);
      exp_g = (c == 6) ? 2'b10 : 2'b01;
      #1;
      checks++; if ({gnt1, gnt0} !== exp_g) begin errors++; $display("FAIL lone_gnt[c%0d]: gnt=%b required %b", c, {gnt1, gnt0}, exp_g); end
      @(posedge clk); #1;
      if (c == 5 || c == 10) begin
        checks++; if (dut.cnt_q !== 3'd4) begin errors++; $display("FAIL cnt_sat[c%0d]: cnt=%0d required 4", c, dut.cnt_q); end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_drop_lock();
    req0 = 1; lock0 = 1;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL drop_c1: gnt0=%b required 1", gnt0); end
    @(posedge clk); #1;
    req1 = 1; lock1 = 1;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL drop_c2_hold: gnt=%b required 01", {gnt1, gnt0}); end
    @(posedge clk); #1;
    req0 = 0; lock0 = 0;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL drop_c3_break: gnt=%b required 10", {gnt1, gnt0}); end
    @(posedge clk); #1;
    checks++; if (dut.lock_vld_q !== 1'b1) begin errors++; $display("FAIL drop_lock_vld: lock_vld=%b required 1", dut.lock_vld_q); end
    req0 = 1;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b10) begin errors++; $display("FAIL drop_c4_lock1: gnt=%b required 10", {gnt1, gnt0}); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    req0 = 1; add0 = 8'h10;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt: gnt0=%b required 1", gnt0); end
    req1 = 1; add1 = 8'h20;
    @(posedge clk);
    rstb = 0;
    #1;
    checks++; if (rvld0 !== 1'b0 || rvld1 !== 1'b0) begin errors++; $display("FAIL mid_rvld_clr: rvld=%b%b required 00", rvld1, rvld0); end
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL mid_gnt_rst: gnt=%b%b en=%b required 00 0", gnt1, gnt0, mem_en); end
    @(posedge clk); #1;
    checks++; if (rvld0 !== 1'b0 || rvld1 !== 1'b0) begin errors++; $display("FAIL mid_rvld_hold: rvld=%b%b required 00", rvld1, rvld0); end
    rstb = 1;
    #1;
    checks++; if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL mid_first_tie: gnt=%b required 01", {gnt1, gnt0}); end
    @(posedge clk); #1;
    checks++; if (rvld0 !== 1'b1 || rvld1 !== 1'b0 || rdat !== 8'hC3) begin
      errors++; $display("FAIL mid_after_rd: rvld=%b%b rdat=%h required 01 c3", rvld1, rvld0, rdat);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hC3;
    mem[8'h20] = 8'h3C;
    mem_datr = 8'h00;
    test_reset();
    test_alternate();
    test_write_read();
    test_lock_burst();
    test_lone_saturate();
    test_drop_lock();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
